// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared reorder buffer constants and entry type
package rob_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int TAG_W     = 5;
  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;

  // One reorder buffer slot; value is only meaningful once done is set.
  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dest;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// rtl/rob_ptr_ctrl.sv - head/tail/occupancy tracking and alloc/commit enables
module rob_ptr_ctrl #(
  parameter int ROB_DEPTH = 32,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_req,
  input  logic             head_ready,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic             full,
  output logic             empty,
  output logic             alloc_en,
  output logic             commit_en
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(ROB_DEPTH);

  // One extra bit so a full buffer is distinguishable from an empty one.
  logic [TAG_W:0] count;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Full refuses allocation even when a commit frees a slot this cycle.
  assign alloc_en  = alloc_req && !full && !flush;
  // A flush discards the head entry, so its pending commit never happens.
  assign commit_en = head_ready && !flush;

  // Pointer and occupancy update; flush behaves like a reset of the pointers.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_en)  tail <= tail + 1'b1;
      if (commit_en) head <= head + 1'b1;
      case ({alloc_en, commit_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order reorder buffer with CDB capture, operand query and commit
module reorder_buffer #(
  parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
  parameter int TAG_W     = rob_pkg::TAG_W,
  parameter int DATA_W    = rob_pkg::DATA_W,
  parameter int REG_W     = rob_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_req,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic              alloc_has_dest,
  output logic [TAG_W-1:0]  rob_tag_alloc,
  output logic              rob_full,
  output logic              rob_empty,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic [TAG_W-1:0]  rs_query_tag,
  input  logic [TAG_W-1:0]  rt_query_tag,
  output logic              rs_query_ready,
  output logic              rt_query_ready,
  output logic [DATA_W-1:0] rs_query_value,
  output logic [DATA_W-1:0] rt_query_value,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_rd,
  output logic              commit_has_dest,
  output logic [DATA_W-1:0] commit_value
);

  // Entry layout comes from the package; parameters must stay equal to its constants.
  rob_pkg::rob_entry_t ent [ROB_DEPTH];

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic             alloc_en;
  logic             commit_en;
  logic             head_ready;

  rob_pkg::rob_entry_t head_e;
  rob_pkg::rob_entry_t rs_e;
  rob_pkg::rob_entry_t rt_e;
  logic                rs_hit;
  logic                rt_hit;

  assign head_e        = ent[head];
  assign head_ready    = head_e.valid && head_e.done;
  assign rob_tag_alloc = tail;

  rob_ptr_ctrl #(
    .ROB_DEPTH (ROB_DEPTH),
    .TAG_W     (TAG_W)
  ) u_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .alloc_req  (alloc_req),
    .head_ready (head_ready),
    .head       (head),
    .tail       (tail),
    .full       (rob_full),
    .empty      (rob_empty),
    .alloc_en   (alloc_en),
    .commit_en  (commit_en)
  );

  // Entry array: commit retires head, CDB completes a live entry, alloc fills tail.
  // These never collide: tail==head only when empty (nothing to commit) or full (no alloc),
  // and a CDB to the not-yet-valid tail slot is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].done  <= 1'b0;
      end
    end else begin
      if (commit_en) ent[head].valid <= 1'b0;
      if (cdb_valid && ent[cdb_tag].valid) begin
        ent[cdb_tag].done  <= 1'b1;
        ent[cdb_tag].value <= cdb_value;
      end
      if (alloc_en) begin
        ent[tail].valid    <= 1'b1;
        ent[tail].done     <= 1'b0;
        ent[tail].has_dest <= alloc_has_dest;
        ent[tail].rd       <= alloc_rd;
        ent[tail].value    <= '0;
      end
    end
  end

  // Commit port is zeroed whenever nothing retires.
  always_comb begin
    commit_valid    = 1'b0;
    commit_tag      = '0;
    commit_rd       = '0;
    commit_has_dest = 1'b0;
    commit_value    = '0;
    if (commit_en) begin
      commit_valid    = 1'b1;
      commit_tag      = head;
      commit_rd       = head_e.rd;
      commit_has_dest = head_e.has_dest;
      commit_value    = head_e.value;
    end
  end

  // Operand queries, forwarding a same-cycle CDB result ahead of the stored value.
  always_comb begin
    rs_e           = ent[rs_query_tag];
    rt_e           = ent[rt_query_tag];
    rs_hit         = cdb_valid && (cdb_tag == rs_query_tag) && rs_e.valid;
    rt_hit         = cdb_valid && (cdb_tag == rt_query_tag) && rt_e.valid;
    rs_query_ready = (rs_e.valid && rs_e.done) || rs_hit;
    rt_query_ready = (rt_e.valid && rt_e.done) || rt_hit;
    rs_query_value = '0;
    rt_query_value = '0;
    if (rs_hit)              rs_query_value = cdb_value;
    else if (rs_query_ready) rs_query_value = rs_e.value;
    if (rt_hit)              rt_query_value = cdb_value;
    else if (rt_query_ready) rt_query_value = rt_e.value;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed scoreboard bench for reorder_buffer
module tb_reorder_buffer;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        alloc_req = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic        alloc_has_dest = 1'b0;
  logic [4:0]  rob_tag_alloc;
  logic        rob_full;
  logic        rob_empty;
  logic        cdb_valid = 1'b0;
  logic [4:0]  cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic [4:0]  rs_query_tag = '0;
  logic [4:0]  rt_query_tag = '0;
  logic        rs_query_ready;
  logic        rt_query_ready;
  logic [31:0] rs_query_value;
  logic [31:0] rt_query_value;
  logic        commit_valid;
  logic [4:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic        commit_has_dest;
  logic [31:0] commit_value;

  reorder_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .alloc_req       (alloc_req),
    .alloc_rd        (alloc_rd),
    .alloc_has_dest  (alloc_has_dest),
    .rob_tag_alloc   (rob_tag_alloc),
    .rob_full        (rob_full),
    .rob_empty       (rob_empty),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_value       (cdb_value),
    .rs_query_tag    (rs_query_tag),
    .rt_query_tag    (rt_query_tag),
    .rs_query_ready  (rs_query_ready),
    .rt_query_ready  (rt_query_ready),
    .rs_query_value  (rs_query_value),
    .rt_query_value  (rt_query_value),
    .commit_valid    (commit_valid),
    .commit_tag      (commit_tag),
    .commit_rd       (commit_rd),
    .commit_has_dest (commit_has_dest),
    .commit_value    (commit_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] tag;
    logic [4:0] rd;
    logic       hd;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] m_val  [DEPTH];
  bit          m_done [DEPTH];
  logic [4:0]  m_tail = '0;
  bit          acc;
  bit          cdb_hit;
  bit          settled = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic bit in_sb(input logic [4:0] t);
    foreach (sb[i]) if (sb[i].tag == t) return 1;
    return 0;
  endfunction

  // Capture what this cycle's inputs should do, then move to edge+4 for checks.
  task automatic settle();
    acc     = alloc_req && !flush && (sb.size() < DEPTH);
    cdb_hit = cdb_valid && !flush && in_sb(cdb_tag);
    if (cdb_hit) m_val[cdb_tag] = cdb_value;
    #3;
    settled = 1;
  endtask

  // Advance one clock and apply the model update that edge performs.
  task automatic step();
    if (!settled) settle();
    @(posedge clk);
    #1;
    settled = 0;
    if (flush) begin
      sb.delete();
      m_tail = '0;
    end else begin
      if (cdb_hit) m_done[cdb_tag] = 1;
      if (acc) begin
        m_done[m_tail] = 0;
        sb.push_back('{m_tail, alloc_rd, alloc_has_dest});
        m_tail++;
      end
    end
    alloc_req = 1'b0;
    cdb_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Commit monitor: retirement must match the oldest completed scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_cv;
      exp_cv = (sb.size() > 0) && m_done[sb[0].tag] && !flush;
      chk("commit_valid", commit_valid, exp_cv);
      if (commit_valid && exp_cv) begin
        sb_t e;
        e = sb.pop_front();
        chk("commit_tag", commit_tag, e.tag);
        chk("commit_rd", commit_rd, e.rd);
        chk("commit_has_dest", commit_has_dest, e.hd);
        chk("commit_value", commit_value, m_val[e.tag]);
      end else if (!commit_valid) begin
        chk("commit_idle_zero", {commit_tag, commit_rd, commit_has_dest, commit_value}, 64'd0);
      end
    end
  end

  initial begin
    logic [4:0] rds [3];
    rds[0] = 5'd4; rds[1] = 5'd7; rds[2] = 5'd9;
    foreach (m_done[i]) begin m_done[i] = 0; m_val[i] = '0; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tag_alloc", rob_tag_alloc, 0);
    chk("rst_full", rob_full, 0);
    chk("rst_empty", rob_empty, 1);
    chk("rst_commit", commit_valid, 0);
    chk("rst_query", {rs_query_ready, rt_query_ready, rs_query_value, rt_query_value}, 0);
    rst_n = 1'b1;

    // Three allocations get tags 0,1,2
    for (int i = 0; i < 3; i++) begin
      alloc_req = 1'b1; alloc_rd = rds[i]; alloc_has_dest = 1'b1;
      settle();
      chk("alloc_tag", rob_tag_alloc, i);
      step();
    end
    chk("tag_after_3", rob_tag_alloc, 3);
    chk("not_empty_3", rob_empty, 0);

    // Out-of-order completion, in-order retirement
    cdb_valid = 1'b1; cdb_tag = 5'd1; cdb_value = 32'h11; step();
    cdb_valid = 1'b1; cdb_tag = 5'd0; cdb_value = 32'h22; step();
    settle();
    chk("retire0_valid", commit_valid, 1);
    chk("retire0_rd", commit_rd, 4);
    chk("retire0_value", commit_value, 32'h22);
    step();
    settle();
    chk("retire1_tag", commit_tag, 1);
    chk("retire1_value", commit_value, 32'h11);
    step();
    settle();
    chk("tag2_held", commit_valid, 0);
    chk("tag2_not_empty", rob_empty, 0);
    step();
    cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_value = 32'h33; step();
    step();
    chk("drained_empty", rob_empty, 1);
    chk("drained_tag", rob_tag_alloc, 3);

    // Ten entries (tags 3..12), then operand queries
    for (int i = 0; i < 10; i++) begin
      alloc_req = 1'b1; alloc_rd = 5'($urandom_range(0, 31)); alloc_has_dest = 1'($urandom_range(0, 1));
      step();
    end
    cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_value = 32'hDEAD;
    rs_query_tag = 5'd5; rt_query_tag = 5'd6;
    settle();
    chk("rs_fwd_ready", rs_query_ready, 1);
    chk("rs_fwd_value", rs_query_value, 32'hDEAD);
    chk("rt_pending", {rt_query_ready, rt_query_value}, 0);
    step();
    chk("rs_stored_ready", rs_query_ready, 1);
    chk("rs_stored_value", rs_query_value, 32'hDEAD);
    cdb_valid = 1'b1; cdb_tag = 5'd20; cdb_value = 32'h1234; rt_query_tag = 5'd20;
    settle();
    chk("rt_invalid_entry", {rt_query_ready, rt_query_value}, 0);
    step();

    // Flush with simultaneous alloc and CDB
    flush = 1'b1; alloc_req = 1'b1; cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 32'h77;
    step();
    chk("flush_empty", rob_empty, 1);
    chk("flush_tag", rob_tag_alloc, 0);
    chk("flush_full", rob_full, 0);
    chk("flush_query", rs_query_ready, 0);

    // Fill to full, refuse the 33rd, then retire-with-alloc-held and wrap
    for (int i = 0; i < DEPTH; i++) begin
      alloc_req = 1'b1; alloc_rd = 5'(i); alloc_has_dest = 1'(i % 2);
      settle();
      chk("fill_tag", rob_tag_alloc, i);
      chk("fill_not_full", rob_full, 0);
      step();
    end
    chk("full_set", rob_full, 1);
    chk("full_tag_wrap", rob_tag_alloc, 0);
    alloc_req = 1'b1; step();
    chk("refused_33rd", rob_tag_alloc, 0);
    chk("still_full", rob_full, 1);
    alloc_req = 1'b1; cdb_valid = 1'b1; cdb_tag = 5'd0; cdb_value = 32'hAAAA; step();
    alloc_req = 1'b1;
    settle();
    chk("full_commit_valid", commit_valid, 1);
    chk("full_commit_full", rob_full, 1);
    step();
    chk("after_commit_tag", rob_tag_alloc, 0);
    chk("after_commit_full", rob_full, 0);
    alloc_req = 1'b1; alloc_rd = 5'd3; alloc_has_dest = 1'b1;
    settle();
    chk("wrap_alloc_tag", rob_tag_alloc, 0);
    step();
    chk("refull", rob_full, 1);

    // Alloc, CDB and commit together at occupancy 5
    flush = 1'b1; step();
    for (int i = 0; i < 5; i++) begin
      alloc_req = 1'b1; alloc_rd = 5'(i + 10); alloc_has_dest = 1'b1;
      step();
    end
    cdb_valid = 1'b1; cdb_tag = 5'd0; cdb_value = 32'h100; step();
    alloc_req = 1'b1; alloc_rd = 5'd15; alloc_has_dest = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_value = 32'h102;
    settle();
    chk("triple_commit", commit_valid, 1);
    step();
    chk("triple_tag", rob_tag_alloc, 6);
    chk("triple_not_empty", rob_empty, 0);
    for (int t = 1; t <= 5; t++) begin
      if (t != 2) begin
        cdb_valid = 1'b1; cdb_tag = 5'(t); cdb_value = 32'h100 + 32'(t);
        step();
      end
    end
    for (int k = 0; k < 10 && !rob_empty; k++) step();
    chk("final_empty", rob_empty, 1);
    chk("empty_vs_model", rob_empty, sb.size() == 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
